// File: rtl/fp16_int_codec.sv
// Iterative int16 <-> binary16 converter with valid/ready on both sides.
// Normalisation and alignment move one bit per cycle; rounding is round-to-nearest-even.
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   NORM  | shifting the working value one bit per cycle
//   ROUND | rounding, packing, flag generation, output registers load
//   DONE  | result presented until out_ready
module fp16_int_codec #(
    parameter logic [15:0] NAN_FP = 16'h7FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    state_t state, state_nxt;

    logic        mode_q, sign_q, left_q, bypass_q, guard_q, sticky_q;
    logic [3:0]  cnt_q;
    logic [4:0]  exp_q;
    logic [15:0] work_q;
    logic [2:0]  byp_flags_q;

    logic        ld_left, ld_bypass;
    logic [3:0]  ld_cnt, lz;
    logic [4:0]  ld_exp, f_exp, f_eff;
    logic [9:0]  f_man;
    logic [10:0] f_sig;
    logic [15:0] ld_work, mag;
    logic [2:0]  ld_flags;

    always_comb begin
        mag   = in_data[15] ? 16'(-in_data) : in_data;
        lz    = 4'd15;
        for (int i = 0; i < 16; i++)
            if (mag[i]) lz = 4'(15 - i);
        f_exp = in_data[14:10];
        f_man = in_data[9:0];
        f_sig = {|f_exp, f_man};
        f_eff = (f_exp == 5'd0) ? 5'd1 : f_exp;

        ld_left   = 1'b1;
        ld_bypass = 1'b0;
        ld_cnt    = 4'd0;
        ld_exp    = 5'd0;
        ld_work   = 16'h0000;
        ld_flags  = 3'b000;
        if (!in_mode) begin
            ld_bypass = (mag == 16'h0000);
            ld_work   = mag;
            ld_cnt    = ld_bypass ? 4'd0 : lz;
            ld_exp    = 5'd30 - {1'b0, lz};
        end else if (f_exp == 5'd31) begin
            ld_bypass = 1'b1;
            ld_flags  = 3'b100;
            ld_work   = (f_man == 10'd0 && !in_data[15]) ? 16'h7FFF : 16'h8000;
        end else if (f_eff < 5'd14) begin
            // |value| < 0.5 always rounds to zero
            ld_bypass = 1'b1;
            ld_flags  = {2'b00, f_sig != 11'd0};
        end else if (f_eff <= 5'd25) begin
            ld_left = 1'b0;
            ld_work = {5'd0, f_sig};
            ld_cnt  = 4'(5'd25 - f_eff);
        end else begin
            ld_work = {5'd0, f_sig};
            ld_cnt  = 4'(f_eff - 5'd25);
        end
    end

    logic        i_g, i_r, i_s, i_up, i_carry, f_up, f_ovf;
    logic [9:0]  i_mant;
    logic [10:0] i_sum;
    logic [4:0]  i_exp;
    logic [16:0] f_mag;
    logic [15:0] res_data;
    logic [2:0]  res_flags;

    always_comb begin
        i_mant  = work_q[14:5];
        i_g     = work_q[4];
        i_r     = work_q[3];
        i_s     = |work_q[2:0];
        i_up    = i_g & (i_r | i_s | i_mant[0]);
        i_sum   = {1'b0, i_mant} + {10'd0, i_up};
        i_carry = i_sum[10];
        i_exp   = exp_q + {4'd0, i_carry};

        f_up    = guard_q & (sticky_q | work_q[0]);
        f_mag   = {1'b0, work_q} + {16'd0, f_up};
        f_ovf   = sign_q ? (f_mag > 17'd32768) : (f_mag > 17'd32767);

        res_data  = 16'h0000;
        res_flags = 3'b000;
        if (bypass_q) begin
            res_data  = work_q;
            res_flags = byp_flags_q;
        end else if (!mode_q) begin
            res_data  = {sign_q, i_exp, i_sum[9:0]};
            res_flags = {2'b00, i_g | i_r | i_s};
        end else if (f_ovf) begin
            res_data  = sign_q ? 16'h8000 : 16'h7FFF;
            res_flags = 3'b010;
        end else begin
            res_data  = sign_q ? 16'(-f_mag[15:0]) : f_mag[15:0];
            res_flags = {2'b00, guard_q | sticky_q};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_valid) state_nxt = (ld_cnt == 4'd0) ? ROUND : NORM;
            NORM:  if (cnt_q == 4'd1) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_q      <= 1'b0;
            sign_q      <= 1'b0;
            left_q      <= 1'b0;
            bypass_q    <= 1'b0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= 4'd0;
            exp_q       <= 5'd0;
            work_q      <= 16'h0000;
            byp_flags_q <= 3'b000;
            out_data    <= 16'h0000;
            out_flags   <= 3'b000;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    mode_q      <= in_mode;
                    sign_q      <= in_data[15];
                    left_q      <= ld_left;
                    bypass_q    <= ld_bypass;
                    guard_q     <= 1'b0;
                    sticky_q    <= 1'b0;
                    cnt_q       <= ld_cnt;
                    exp_q       <= ld_exp;
                    work_q      <= ld_work;
                    byp_flags_q <= ld_flags;
                end
                NORM: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (left_q) begin
                        work_q <= {work_q[14:0], 1'b0};
                    end else begin
                        work_q   <= {1'b0, work_q[15:1]};
                        guard_q  <= work_q[0];
                        sticky_q <= sticky_q | guard_q;
                    end
                end
                ROUND: begin
                    out_data  <= res_data;
                    out_flags <= res_flags;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Integer sources top out at exponent 30, so they can never alias the NaN pattern.
    no_nan_from_int: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !mode_q) |-> (out_data != NAN_FP));

endmodule

// File: tb/tb_fp16_int_codec.sv
// Randomised and directed bench for fp16_int_codec against an arithmetic reference model.
module tb_fp16_int_codec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic [2:0]  out_flags;

    int n_checks = 0;
    int n_errors = 0;

    fp16_int_codec dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: value = a, scaled to an 11-bit significand with RNE on the remainder.
    function automatic void ref_i2f(input logic [15:0] x, output logic [15:0] r,
                                    output logic [2:0] f, output int n);
        longint v, a, q, rem, dv;
        int k;
        v = longint'($signed(x));
        a = (v < 0) ? -v : v;
        r = 16'h0000; f = 3'b000; n = 0;
        if (a != 0) begin
            k = 0;
            while ((longint'(1) <<< (k + 1)) <= a) k++;
            n = 15 - k;
            rem = 0;
            if (k <= 10) begin
                q = a <<< (10 - k);
            end else begin
                dv  = longint'(1) <<< (k - 10);
                q   = a / dv;
                rem = a % dv;
                if (rem * 2 > dv || (rem * 2 == dv && q % 2 == 1)) q++;
            end
            if (q == 2048) begin q = 1024; k++; end
            r = {v < 0, 5'(k + 15), 10'(q - 1024)};
            f = {2'b00, rem != 0};
        end
    endfunction

    // Reference: value = s * 2^(eff-25), rounded to an integer by RNE, then saturated.
    function automatic void ref_f2i(input logic [15:0] x, output logic [15:0] r,
                                    output logic [2:0] f, output int n);
        int e, eff;
        longint s, q, rem, dv;
        logic neg;
        neg = x[15];
        e = int'(x[14:10]);
        r = 16'h0000; f = 3'b000; n = 0;
        if (e == 31) begin
            f = 3'b100;
            r = (x[9:0] == 10'd0 && !neg) ? 16'h7FFF : 16'h8000;
        end else begin
            eff = (e == 0) ? 1 : e;
            s = ((e == 0) ? 0 : 1024) + longint'(x[9:0]);
            rem = 0;
            if (eff >= 25) begin
                q = s <<< (eff - 25);
                n = eff - 25;
            end else begin
                dv  = longint'(1) <<< (25 - eff);
                q   = s / dv;
                rem = s % dv;
                if (rem * 2 > dv || (rem * 2 == dv && q % 2 == 1)) q++;
                n = (eff < 14) ? 0 : 25 - eff;
            end
            if (!neg && q > 32767) begin
                r = 16'h7FFF; f = 3'b010;
            end else if (neg && q > 32768) begin
                r = 16'h8000; f = 3'b010;
            end else begin
                r = neg ? 16'(-q) : 16'(q);
                f = {2'b00, rem != 0};
            end
        end
    endfunction

    // Latency counts rising edges from the acceptance edge up to the one that raises out_valid.
    task automatic run(input logic mode, input logic [15:0] data, input logic [15:0] exp_d,
                       input logic [2:0] exp_f, input int exp_lat);
        int cyc;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_mode = mode; in_data = data; out_ready = 1'b1;
        @(posedge clk); cyc = 1; #1;
        in_valid = 1'b0;
        check("in_ready_busy", in_ready, 0);
        while (!out_valid && cyc < 40) begin @(posedge clk); cyc++; #1; end
        check("latency", cyc, exp_lat);
        check("data", out_data, exp_d);
        check("flags", out_flags, exp_f);
        @(posedge clk); #1;
        check("out_valid_drop", out_valid, 0);
    endtask

    task automatic run_model(input logic mode, input logic [15:0] data);
        logic [15:0] r;
        logic [2:0]  f;
        int n;
        if (mode) ref_f2i(data, r, f, n);
        else      ref_i2f(data, r, f, n);
        run(mode, data, r, f, n + 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic [15:0] x;
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
        #22 rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_out_flags", out_flags, 3'b000);

        run(1'b0, 16'h0001, 16'h3C00, 3'b000, 17);
        run(1'b0, 16'h0000, 16'h0000, 3'b000, 2);
        run(1'b0, 16'd2049, 16'h6800, 3'b001, 6);
        run(1'b0, 16'd2051, 16'h6802, 3'b001, 6);
        run(1'b0, 16'h8000, 16'hF800, 3'b000, 2);
        run(1'b0, 16'h7FFF, 16'h7800, 3'b001, 3);
        run(1'b1, 16'h3E00, 16'h0002, 3'b001, 12);
        run(1'b1, 16'h4100, 16'h0002, 3'b001, 11);
        run(1'b1, 16'h3800, 16'h0000, 3'b001, 13);
        run(1'b1, 16'hBE00, 16'hFFFE, 3'b001, 12);
        run(1'b1, 16'h0001, 16'h0000, 3'b001, 2);
        run(1'b1, 16'h7C00, 16'h7FFF, 3'b100, 2);
        run(1'b1, 16'h7E00, 16'h8000, 3'b100, 2);
        run(1'b1, 16'h7800, 16'h7FFF, 3'b010, 7);
        run(1'b1, 16'hF800, 16'h8000, 3'b000, 7);

        for (int i = 0; i < 80; i++) run_model(1'b0, 16'($urandom));
        for (int i = 0; i < 40; i++) run_model(1'b1, 16'($urandom));
        for (int i = 0; i < 60; i++) begin
            x = 16'($urandom);
            x[14:10] = 5'($urandom_range(13, 30));
            run_model(1'b1, x);
        end

        // Backpressure: result must hold and new requests must be ignored.
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b0; in_data = 16'd2051; out_ready = 1'b0;
        @(posedge clk); cyc = 1; #1;
        in_valid = 1'b0;
        while (!out_valid && cyc < 40) begin @(posedge clk); cyc++; #1; end
        check("bp_latency", cyc, 6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_mode = 1'b1; in_data = 16'h3C00;
            @(posedge clk); #1;
            check("bp_valid_held", out_valid, 1);
            check("bp_data_held", out_data, 16'h6802);
            check("bp_flags_held", out_flags, 3'b001);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        check("bp_ignored", out_valid, 0);

        // Reset in the middle of a long normalisation.
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b0; in_data = 16'h0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_data", out_data, 16'h0000);
        check("mid_rst_out_flags", out_flags, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_no_stale", out_valid, 0);
        run(1'b0, 16'h0400, 16'h6400, 3'b000, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
